// File: rtl/xrbase_alfred_irq_pkg.sv
// Shared types and constants for the alfred interrupt controller.
package xrbase_alfred_irq_pkg;
   localparam int unsigned NUM_IRQ_DEF = 33;
   localparam int unsigned ID_W        = 6;

   typedef enum logic [1:0] {
      IDLE,
      PRESENT,
      SERVICE
   } irq_state_e;
endpackage

// File: rtl/xrbase_alfred_irq_if.sv
// Source vector plus claim/end-of-interrupt handshake between the core and the controller.
interface xrbase_alfred_irq_if
   import xrbase_alfred_irq_pkg::*;
   #(parameter int unsigned NUM_IRQ = NUM_IRQ_DEF);

   logic [NUM_IRQ-1:0] irq_in;
   logic               claim_valid;
   logic [ID_W-1:0]    claim_id;
   logic               claim_ready;
   logic               eoi_valid;
   logic [ID_W-1:0]    eoi_id;

   modport master (
      output irq_in, claim_ready, eoi_valid, eoi_id,
      input  claim_valid, claim_id
   );

   modport slave (
      input  irq_in, claim_ready, eoi_valid, eoi_id,
      output claim_valid, claim_id
   );
endinterface

// File: rtl/xrbase_alfred_irq_sync.sv
// Single-bit multi-flop synchronizer for an asynchronous interrupt source.
module xrbase_alfred_irq_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [SYNC_STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff <= '0;
      else        ff <= {ff[SYNC_STAGES-2:0], d};
   end

   assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/xrbase_alfred_irq_ctrl.sv
// Interrupt controller: synchronize, latch/track pending sources, offer the lowest
// enabled one to the core and hold it until end-of-interrupt.
module xrbase_alfred_irq_ctrl
   import xrbase_alfred_irq_pkg::*;
   #(
   parameter int unsigned NUM_IRQ     = NUM_IRQ_DEF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   xrbase_alfred_irq_if.slave  bus,
   input  logic [NUM_IRQ-1:0]  irq_en,
   input  logic [NUM_IRQ-1:0]  irq_edge,
   output logic                irq_out,
   output logic [NUM_IRQ-1:0]  pending
);
   irq_state_e         state, state_n;
   logic [NUM_IRQ-1:0] sync, samp, samp_d, pend_n, active;
   logic [ID_W-1:0]    lowest_id;
   logic               any_active, claim_fire, load_id;

   for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
      xrbase_alfred_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (bus.irq_in[i]),
         .q     (sync[i])
      );
   end

   // samp/samp_d give the edge detector its previous value one stage after the synchronizer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp    <= '0;
         samp_d  <= '0;
         pending <= '0;
      end else begin
         samp    <= sync;
         samp_d  <= samp;
         pending <= pend_n;
      end
   end

   assign claim_fire = (state == PRESENT) && bus.claim_ready;

   always_comb begin
      pend_n = pending;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         if (irq_edge[i]) begin
            if (samp[i] && !samp_d[i])
               pend_n[i] = 1'b1;
            else if (claim_fire && (bus.claim_id == ID_W'(i)))
               pend_n[i] = 1'b0;
         end else begin
            pend_n[i] = samp[i];
         end
      end
   end

   assign active     = pending & irq_en;
   assign any_active = |active;

   // scan from the top so the lowest set index is the last one written
   always_comb begin
      lowest_id = '0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         if (active[NUM_IRQ-1-i]) lowest_id = ID_W'(NUM_IRQ-1-i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n         = state;
      load_id         = 1'b0;
      bus.claim_valid = 1'b0;
      irq_out         = 1'b0;
      case (state)
         IDLE: begin
            irq_out = any_active;
            if (any_active) begin
               load_id = 1'b1;
               state_n = PRESENT;
            end
         end
         PRESENT: begin
            bus.claim_valid = 1'b1;
            irq_out         = 1'b1;
            if (bus.claim_ready) state_n = SERVICE;
         end
         SERVICE: begin
            if (bus.eoi_valid && (bus.eoi_id == bus.claim_id)) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       bus.claim_id <= '0;
      else if (load_id) bus.claim_id <= lowest_id;
   end
endmodule

// File: tb/tb_xrbase_alfred_irq_ctrl.sv
// Directed bench for the alfred interrupt controller with hand-computed expectations.
module tb_xrbase_alfred_irq_ctrl;
   localparam int unsigned N = 33;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] irq_en;
   logic [N-1:0] irq_edge;
   logic         irq_out;
   logic [N-1:0] pending;
   int           checks;
   int           errors;

   xrbase_alfred_irq_if #(.NUM_IRQ(N)) bus ();

   xrbase_alfred_irq_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .irq_en   (irq_en),
      .irq_edge (irq_edge),
      .irq_out  (irq_out),
      .pending  (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int unsigned src);
      bus.irq_in[src] = 1'b1;
      tick();
      bus.irq_in[src] = 1'b0;
   endtask

   task automatic claim();
      bus.claim_ready = 1'b1;
      tick();
      bus.claim_ready = 1'b0;
   endtask

   task automatic eoi(input int unsigned id);
      bus.eoi_valid = 1'b1;
      bus.eoi_id    = 6'(id);
      tick();
      bus.eoi_valid = 1'b0;
   endtask

   task automatic wait_offer(input string tag);
      int n = 0;
      while (!bus.claim_valid && n < 50) begin
         tick();
         n++;
      end
      check({tag, "_offer"}, 64'(bus.claim_valid), 64'd1);
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      rst_n           = 1'b0;
      irq_en          = '0;
      irq_edge        = '0;
      bus.irq_in      = '0;
      bus.claim_ready = 1'b0;
      bus.eoi_valid   = 1'b0;
      bus.eoi_id      = '0;
      repeat (3) tick();
      check("rst_claim_valid", 64'(bus.claim_valid), 64'd0);
      check("rst_irq_out",     64'(irq_out),         64'd0);
      check("rst_pending",     64'(pending),         64'd0);
      check("rst_claim_id",    64'(bus.claim_id),    64'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      // single-cycle edge pulse on 5: latency, then enable drop during offer
      irq_edge[5] = 1'b1;
      irq_en[5]   = 1'b1;
      pulse(5);
      repeat (3) tick();
      check("lat_pending5",   64'(pending[5]),      64'd1);
      check("lat_cv_early",   64'(bus.claim_valid), 64'd0);
      check("lat_irq_out",    64'(irq_out),         64'd1);
      tick();
      check("lat_cv",         64'(bus.claim_valid), 64'd1);
      check("lat_id",         64'(bus.claim_id),    64'd5);
      irq_en[5] = 1'b0;
      repeat (3) tick();
      check("hold_cv",        64'(bus.claim_valid), 64'd1);
      check("hold_id",        64'(bus.claim_id),    64'd5);
      check("hold_irq_out",   64'(irq_out),         64'd1);
      claim();
      check("clr_pending5",   64'(pending[5]),      64'd0);
      check("svc_cv",         64'(bus.claim_valid), 64'd0);
      check("svc_irq_out",    64'(irq_out),         64'd0);
      eoi(5);
      check("idle_irq_out",   64'(irq_out),         64'd0);
      irq_edge[5] = 1'b0;

      // level sources 3 and 20
      irq_en[3]  = 1'b1;
      irq_en[20] = 1'b1;
      bus.irq_in[3]  = 1'b1;
      bus.irq_in[20] = 1'b1;
      wait_offer("lvl_a");
      check("lvl_id3",        64'(bus.claim_id),    64'd3);
      claim();
      check("lvl_pend3_kept", 64'(pending[3]),      64'd1);
      eoi(3);
      check("lvl_idle_irq",   64'(irq_out),         64'd1);
      check("lvl_idle_cv",    64'(bus.claim_valid), 64'd0);
      tick();
      check("lvl_reclaim_cv", 64'(bus.claim_valid), 64'd1);
      check("lvl_reclaim_id", 64'(bus.claim_id),    64'd3);
      claim();
      bus.irq_in[3] = 1'b0;
      repeat (5) tick();
      check("lvl_pend3_drop", 64'(pending[3]),      64'd0);
      check("lvl_pend20",     64'(pending[20]),     64'd1);
      eoi(3);
      tick();
      check("lvl_id20_cv",    64'(bus.claim_valid), 64'd1);
      check("lvl_id20",       64'(bus.claim_id),    64'd20);
      claim();
      bus.irq_in[20] = 1'b0;
      repeat (5) tick();
      eoi(20);
      check("lvl_done_irq",   64'(irq_out),         64'd0);
      irq_en[3]  = 1'b0;
      irq_en[20] = 1'b0;

      // eoi id mismatch, and eoi outside SERVICE
      irq_edge[7] = 1'b1;
      irq_edge[9] = 1'b1;
      irq_en[7]   = 1'b1;
      irq_en[9]   = 1'b1;
      bus.irq_in[7] = 1'b1;
      bus.irq_in[9] = 1'b1;
      tick();
      bus.irq_in[7] = 1'b0;
      bus.irq_in[9] = 1'b0;
      wait_offer("eoi_a");
      check("eoi_id7",        64'(bus.claim_id),    64'd7);
      claim();
      check("eoi_pend9",      64'(pending[9]),      64'd1);
      check("eoi_svc_irq",    64'(irq_out),         64'd0);
      eoi(8);
      check("eoi_bad_cv",     64'(bus.claim_valid), 64'd0);
      tick();
      check("eoi_bad_irq",    64'(irq_out),         64'd0);
      eoi(7);
      check("eoi_ok_irq",     64'(irq_out),         64'd1);
      check("eoi_ok_cv",      64'(bus.claim_valid), 64'd0);
      tick();
      check("eoi_next_cv",    64'(bus.claim_valid), 64'd1);
      check("eoi_next_id",    64'(bus.claim_id),    64'd9);
      eoi(9);
      check("eoi_pres_cv",    64'(bus.claim_valid), 64'd1);
      check("eoi_pres_id",    64'(bus.claim_id),    64'd9);
      claim();
      eoi(9);
      check("eoi_done_irq",   64'(irq_out),         64'd0);
      irq_en[7] = 1'b0;
      irq_en[9] = 1'b0;

      // edge on 32 coinciding with its claim: set must win
      irq_edge[32] = 1'b1;
      irq_en[32]   = 1'b1;
      pulse(32);
      wait_offer("race_a");
      check("race_id32",      64'(bus.claim_id),    64'd32);
      bus.irq_in[32] = 1'b1;
      tick();
      bus.irq_in[32] = 1'b0;
      tick();
      tick();
      bus.claim_ready = 1'b1;
      tick();
      bus.claim_ready = 1'b0;
      check("race_pend32",    64'(pending[32]),     64'd1);
      check("race_svc_cv",    64'(bus.claim_valid), 64'd0);
      eoi(32);
      check("race_idle_irq",  64'(irq_out),         64'd1);
      tick();
      check("race_reoffer",   64'(bus.claim_valid), 64'd1);
      check("race_reid",      64'(bus.claim_id),    64'd32);
      claim();
      check("race_clr",       64'(pending[32]),     64'd0);
      eoi(32);
      irq_en[32] = 1'b0;

      // asynchronous reset during an offer
      irq_edge[12] = 1'b1;
      irq_en[12]   = 1'b1;
      pulse(12);
      wait_offer("rst_a");
      check("rst_id12",       64'(bus.claim_id),    64'd12);
      #1 rst_n = 1'b0;
      #2;
      check("arst_cv",        64'(bus.claim_valid), 64'd0);
      check("arst_irq",       64'(irq_out),         64'd0);
      check("arst_pending",   64'(pending),         64'd0);
      check("arst_id",        64'(bus.claim_id),    64'd0);
      #2 rst_n = 1'b1;
      repeat (10) tick();
      check("post_cv",        64'(bus.claim_valid), 64'd0);
      check("post_irq",       64'(irq_out),         64'd0);
      check("post_pending",   64'(pending),         64'd0);
      pulse(12);
      wait_offer("post");
      check("post_id12",      64'(bus.claim_id),    64'd12);
      claim();
      eoi(12);
      check("post_done_irq",  64'(irq_out),         64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/xrbase_alfred_irq_ctrl.md
XRBASE_ALFRED_IRQ_CTRL -- requirements
Module: xrbase_alfred_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 33, number of interrupt sources.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (2..3).
REQ-003 SHALL have one clock and an asynchronous, active-low reset, as already decided.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 irq_in  input  NUM_IRQ  raw sources; consumes the irq vector of the alfred irq interface (sp modport); asynchronous to clk.
REQ-007 irq_en  input  NUM_IRQ  per-source enable; quasi-static.
REQ-008 irq_edge  input  NUM_IRQ  per-source mode: 1 = rising-edge latched, 0 = level.
REQ-009 irq_out  output  1  interrupt request to the core.
REQ-010 claim_valid  output  1  claim offer valid.
REQ-011 claim_id  output  6  index of the offered source.
REQ-012 claim_ready  input  1  core accepts the claim.
REQ-013 eoi_valid  input  1  end-of-interrupt strobe.
REQ-014 eoi_id  input  6  source completed.
REQ-015 pending  output  NUM_IRQ  registered pending status, before enable masking.

Function
REQ-016 Each irq_in bit SHALL pass through SYNC_STAGES flops before any use.
REQ-017 Edge source: pending bit SHALL set on synchronized 0->1 transition and hold until cleared by claim.
REQ-018 Level source: pending bit SHALL equal the synchronized level, registered, with no latching.
REQ-019 Same-cycle edge set and claim clear on one source: set SHALL win.
REQ-020 FSM states SHALL be IDLE, PRESENT and SERVICE.
REQ-021 IDLE->PRESENT when any (pending & irq_en) is set; claim_id SHALL be the lowest set index, registered on the transition.
REQ-022 PRESENT: claim_valid=1 and claim_id stable until claim_ready; enable or pending dropping SHALL NOT withdraw the offer.
REQ-023 PRESENT & claim_ready -> SERVICE; an edge-mode pending bit for claim_id SHALL clear that cycle.
REQ-024 SERVICE -> IDLE only on eoi_valid with eoi_id == claim_id; a mismatching eoi SHALL be ignored.
REQ-025 eoi_valid outside SERVICE SHALL be ignored.
REQ-026 irq_out SHALL be 1 in PRESENT, or in IDLE when any (pending & irq_en) is set; otherwise 0.
REQ-027 Latency: irq_in high sampled at edge 0 (SYNC_STAGES=2) -> pending visible after edge 3 -> claim_valid after edge 4.
REQ-028 Nested interrupts SHALL NOT be supported; new requests stay pending during SERVICE.
REQ-029 Source indices >= NUM_IRQ SHALL never be offered.

Reset
REQ-030 On rst_n low, synchronizers, pending, FSM (IDLE), claim_id (0), claim_valid (0) and irq_out (0) SHALL clear immediately and asynchronously.
REQ-031 Reset mid-claim SHALL drop the offer; edge events latched before reset SHALL be lost.
REQ-032 Reset deassertion SHALL require no extra synchronization inside this block.

Structure
REQ-033 Package xrbase_alfred_irq_pkg SHALL hold the FSM state enum, NUM_IRQ default and ID width constant (6).
REQ-034 Sub-module xrbase_alfred_irq_sync (per-bit multi-flop synchronizer) SHALL be instantiated NUM_IRQ wide.
REQ-035 Priority encoder SHALL be combinational, lowest index first, in the top module.

Verification
REQ-036 irq_edge[5]=1, irq_en[5]=1, pulse irq_in[5] for 1 cycle -> claim_valid=1, claim_id=5 four cycles later; after claim_ready, pending[5]=0.
REQ-037 Level sources 3 and 20 held high, both enabled -> claim_id=3; eoi_id=3 while 3 stays high -> reclaim id 3 next; drop 3 -> id 20.
REQ-038 In SERVICE with id 7, eoi_id=8 -> state unchanged; then eoi_id=7 -> IDLE and irq_out follows remaining pending sources.
REQ-039 Edge on source 32 in the same cycle as claim_ready for id 32 -> pending[32] stays 1 and it is re-offered after eoi.
REQ-040 Deassert irq_en[5] during PRESENT with id 5 -> claim_valid and claim_id=5 held until claim_ready.
REQ-041 rst_n low during PRESENT -> claim_valid, irq_out, pending go 0 without a clock edge; after release, nothing is offered until new irq_in activity.
